// File: rtl/spram_burst_reader.sv
// Read-side burst sequencer for a single-port RAM: issues credit-limited reads,
// tracks the RAM read latency with a tag pipe and streams returns through a small FIFO.
module spram_burst_reader #(
  parameter int DW         = 64,
  parameter int AW         = 8,
  parameter int DEPTH      = 256,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last
);

  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + RD_LAT + 1);
  localparam int DCW = $clog2(RD_LAT + 1);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_LAST   = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);
  localparam logic [AW:0]   LEN_ONE    = (AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_FLUSH = 2'd3
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   addr_d;
  logic [AW:0]     remaining_q;
  logic [AW:0]     wr_left_q;
  logic [DCW-1:0]  drain_q;
  logic            cs_q;
  logic            busy_q;
  logic            done_zero_q;
  logic [RD_LAT-1:0] tag_q;
  logic [RD_LAT-1:0] tag_d;
  logic [CW-1:0]   inflight_q;

  logic [DW:0]     buf_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            m_valid_q;
  logic [DW-1:0]   m_data_q;
  logic            m_last_q;

  logic [CW-1:0]   fifo_count_s;
  logic            credit_s;
  logic            issue_s;
  logic            ret_s;
  logic            pop_s;
  logic            load_s;
  logic            from_buf_s;
  logic            bypass_s;
  logic            push_buf_s;
  logic            last_s;
  logic            done_hs_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  // Credit, tag pipe and FIFO steering decisions for the current cycle
  always_comb begin
    fifo_count_s = cnt_q + CW'(m_valid_q);
    credit_s     = (fifo_count_s + inflight_q) < CREDIT_MAX;
    issue_s      = (state_q == S_ISSUE) && credit_s;
    ret_s        = tag_q[RD_LAT-1];
    pop_s        = m_valid_q && m_ready;
    load_s       = !m_valid_q || pop_s;
    from_buf_s   = load_s && (cnt_q != {CW{1'b0}});
    bypass_s     = load_s && (cnt_q == {CW{1'b0}}) && ret_s;
    push_buf_s   = ret_s && !bypass_s;
    last_s       = (wr_left_q == LEN_ONE);
    done_hs_s    = (state_q == S_FLUSH) && pop_s && m_last_q;
    addr_d       = (addr_q == LAST_ADDR) ? {AW{1'b0}} : addr_q + AW'(1);
    tag_d        = {RD_LAT{1'b0}};
    tag_d[0]     = issue_s;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Burst FSM with address, remaining count and latency tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= {AW{1'b0}};
      remaining_q <= {(AW+1){1'b0}};
      wr_left_q   <= {(AW+1){1'b0}};
      drain_q     <= {DCW{1'b0}};
      cs_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_zero_q <= 1'b0;
      tag_q       <= {RD_LAT{1'b0}};
      inflight_q  <= {CW{1'b0}};
    end else begin
      done_zero_q <= 1'b0;
      tag_q       <= tag_d;
      inflight_q  <= inflight_q + CW'(issue_s) - CW'(ret_s);
      if (ret_s) begin
        wr_left_q <= wr_left_q - LEN_ONE;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (len != {(AW+1){1'b0}}) begin
              state_q     <= S_ISSUE;
              addr_q      <= base_addr;
              remaining_q <= len;
              wr_left_q   <= len;
              cs_q        <= 1'b1;
              busy_q      <= 1'b1;
            end else begin
              done_zero_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (issue_s) begin
            addr_q      <= addr_d;
            remaining_q <= remaining_q - LEN_ONE;
            if (remaining_q == LEN_ONE) begin
              if (RD_LAT > 1) begin
                state_q <= S_DRAIN;
                drain_q <= DCW'(RD_LAT - 1);
              end else begin
                state_q <= S_FLUSH;
                cs_q    <= 1'b0;
              end
            end
          end
        end
        // Keep the RAM delay chain moving until the last read has emerged
        S_DRAIN: begin
          drain_q <= drain_q - DCW'(1);
          if (drain_q == DCW'(1)) begin
            state_q <= S_FLUSH;
            cs_q    <= 1'b0;
          end
        end
        S_FLUSH: begin
          if (done_hs_s) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cs_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage; contents need no reset because occupancy is tracked separately
  always_ff @(posedge clk) begin
    if (push_buf_s) begin
      buf_q[wr_ptr_q] <= {last_s, mem_rdata};
    end
  end

  // FIFO pointers and registered stream head; returns bypass into an empty head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= {PW{1'b0}};
      rd_ptr_q  <= {PW{1'b0}};
      cnt_q     <= {CW{1'b0}};
      m_valid_q <= 1'b0;
      m_data_q  <= {DW{1'b0}};
      m_last_q  <= 1'b0;
    end else begin
      if (push_buf_s) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (from_buf_s) begin
        m_data_q  <= buf_q[rd_ptr_q][DW-1:0];
        m_last_q  <= buf_q[rd_ptr_q][DW];
        m_valid_q <= 1'b1;
        rd_ptr_q  <= ptr_inc(rd_ptr_q);
      end else if (bypass_s) begin
        m_data_q  <= mem_rdata;
        m_last_q  <= last_s;
        m_valid_q <= 1'b1;
      end else if (pop_s) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end
      cnt_q <= cnt_q + CW'(push_buf_s) - CW'(from_buf_s);
    end
  end

  assign busy     = busy_q;
  assign done     = done_zero_q | done_hs_s;
  assign mem_cs   = cs_q;
  assign mem_we   = 1'b0;
  assign mem_addr = addr_q;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_last   = m_last_q;

endmodule

// File: tb/tb_spram_burst_reader.sv
// Directed bench for spram_burst_reader: three instances (default, DEPTH=208, RD_LAT=3)
// each backed by a behavioural RAM whose word content is a function of its address.
module tb_spram_burst_reader;

  logic        clk;
  logic        rst;
  logic        start_s [3];
  logic [7:0]  base_s  [3];
  logic [8:0]  len_s   [3];
  logic        rdy_s   [3];
  logic        busy_s  [3];
  logic        done_s  [3];
  logic        cs_s    [3];
  logic        we_s    [3];
  logic        valid_s [3];
  logic        last_s  [3];
  logic [7:0]  addr_s  [3];
  logic [63:0] rdata_s [3];
  logic [63:0] data_s  [3];
  logic [63:0] pipe2   [2];
  logic [64:0] bq0 [$];
  logic [64:0] bq1 [$];
  logic [64:0] bq2 [$];
  int n_cmp;
  int n_bad;
  int max_occ;

  spram_burst_reader u0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .base_addr(base_s[0]), .len(len_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .mem_cs(cs_s[0]), .mem_we(we_s[0]),
    .mem_addr(addr_s[0]), .mem_rdata(rdata_s[0]), .m_valid(valid_s[0]),
    .m_ready(rdy_s[0]), .m_data(data_s[0]), .m_last(last_s[0]));

  spram_burst_reader #(.DEPTH(208)) u1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .base_addr(base_s[1]), .len(len_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .mem_cs(cs_s[1]), .mem_we(we_s[1]),
    .mem_addr(addr_s[1]), .mem_rdata(rdata_s[1]), .m_valid(valid_s[1]),
    .m_ready(rdy_s[1]), .m_data(data_s[1]), .m_last(last_s[1]));

  spram_burst_reader #(.RD_LAT(3)) u2 (
    .clk(clk), .rst(rst), .start(start_s[2]), .base_addr(base_s[2]), .len(len_s[2]),
    .busy(busy_s[2]), .done(done_s[2]), .mem_cs(cs_s[2]), .mem_we(we_s[2]),
    .mem_addr(addr_s[2]), .mem_rdata(rdata_s[2]), .m_valid(valid_s[2]),
    .m_ready(rdy_s[2]), .m_data(data_s[2]), .m_last(last_s[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] mem_word(input logic [7:0] a);
    return {a, 8'hA5, 40'h12_3456_789A, ~a};
  endfunction

  // RAM models: delay chains advance only while chip select is high
  always_ff @(posedge clk) begin
    if (cs_s[0]) rdata_s[0] <= mem_word(addr_s[0]);
    if (cs_s[1]) rdata_s[1] <= mem_word(addr_s[1]);
    if (cs_s[2]) begin
      pipe2[0]   <= mem_word(addr_s[2]);
      pipe2[1]   <= pipe2[0];
      rdata_s[2] <= pipe2[1];
    end
  end

  // Stream monitor: record every handshaken beat and FIFO occupancy of the RD_LAT=3 unit
  always @(negedge clk) begin
    if (valid_s[0] && rdy_s[0]) bq0.push_back({last_s[0], data_s[0]});
    if (valid_s[1] && rdy_s[1]) bq1.push_back({last_s[1], data_s[1]});
    if (valid_s[2] && rdy_s[2]) bq2.push_back({last_s[2], data_s[2]});
    if (int'(u2.fifo_count_s) > max_occ) max_occ = int'(u2.fifo_count_s);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle (cycle 0); returns early in cycle 1
  task automatic burst_start(input int idx, input logic [7:0] base, input logic [8:0] len);
    cyc();
    start_s[idx] = 1'b1;
    base_s[idx]  = base;
    len_s[idx]   = len;
    cyc();
    start_s[idx] = 1'b0;
  endtask

  task automatic wait_done(input int idx, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (done_s[idx]) begin
        seen = 1'b1;
        chk("done_with_last_hs", {61'd0, valid_s[idx], rdy_s[idx], last_s[idx]}, 64'd7);
      end
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
    cyc();
    chk("busy_after_done", {63'd0, busy_s[idx]}, 64'd0);
  endtask

  task automatic check_beats(input int idx, input int base, input int len, input int depth);
    logic [64:0] got [$];
    int a;
    case (idx)
      0: begin got = bq0; bq0.delete(); end
      1: begin got = bq1; bq1.delete(); end
      default: begin got = bq2; bq2.delete(); end
    endcase
    chk("beat_count", 64'(got.size()), 64'(len));
    for (int i = 0; i < got.size() && i < len; i++) begin
      a = (base + i) % depth;
      chk("beat_data", got[i][63:0], mem_word(8'(a)));
      chk("beat_last", {63'd0, got[i][64]}, {63'd0, (i == len - 1)});
    end
  endtask

  initial begin
    logic [7:0] wa [4];
    logic [7:0] wb [4];
    int first_v;
    bit seen;
    n_cmp = 0;
    n_bad = 0;
    max_occ = 0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0; base_s[i] = 8'd0; len_s[i] = 9'd0; rdy_s[i] = 1'b1;
    end
    repeat (2) cyc();
    chk("reset_ctl", {58'd0, busy_s[0], done_s[0], cs_s[0], we_s[0], valid_s[0], last_s[0]}, 64'd0);
    chk("reset_addr", {56'd0, addr_s[0]}, 64'd0);
    chk("reset_data", data_s[0], 64'd0);
    rst = 1'b0;

    // Basic burst: exact cycle-by-cycle timing
    burst_start(0, 8'h10, 9'd4);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk("t1_cs", {63'd0, cs_s[0]}, {63'd0, (c <= 4)});
      if (c <= 4) chk("t1_addr", {56'd0, addr_s[0]}, 64'(8'h10 + c - 1));
      chk("t1_valid", {63'd0, valid_s[0]}, {63'd0, (c >= 3 && c <= 6)});
      if (c >= 3 && c <= 6) chk("t1_data", data_s[0], mem_word(8'(16 + c - 3)));
      chk("t1_last", {63'd0, last_s[0]}, {63'd0, (c == 6)});
      chk("t1_done", {63'd0, done_s[0]}, {63'd0, (c == 6)});
      chk("t1_busy", {63'd0, busy_s[0]}, {63'd0, (c <= 6)});
    end
    cyc();
    check_beats(0, 16, 4, 256);

    // Address wrap at DEPTH=256 and DEPTH=208
    wa = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    burst_start(0, 8'hFE, 9'd4);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t2_wrap256_addr", {56'd0, addr_s[0]}, {56'd0, wa[c]});
    end
    wait_done(0, 20);
    check_beats(0, 254, 4, 256);
    wb = '{8'd206, 8'd207, 8'd0, 8'd1};
    burst_start(1, 8'd206, 9'd4);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t2_wrap208_addr", {56'd0, addr_s[1]}, {56'd0, wb[c]});
    end
    wait_done(1, 20);
    check_beats(1, 206, 4, 208);

    // Backpressure: four credited reads, then bubbles holding the address
    rdy_s[0] = 1'b0;
    burst_start(0, 8'h50, 9'd10);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk("t3_cs", {63'd0, cs_s[0]}, 64'd1);
      chk("t3_addr", {56'd0, addr_s[0]}, (c <= 4) ? 64'(8'h50 + c - 1) : 64'h54);
    end
    chk("t3_held_valid", {63'd0, valid_s[0]}, 64'd1);
    chk("t3_held_data", data_s[0], mem_word(8'h50));
    cyc();
    rdy_s[0] = 1'b1;
    wait_done(0, 40);
    check_beats(0, 80, 10, 256);

    // Zero-length command and a start pulse while busy
    burst_start(0, 8'h33, 9'd0);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk("t4_len0_done", {63'd0, done_s[0]}, {63'd0, (c == 1)});
      chk("t4_len0_busy", {63'd0, busy_s[0]}, 64'd0);
      chk("t4_len0_cs", {63'd0, cs_s[0]}, 64'd0);
    end
    burst_start(0, 8'h20, 9'd3);
    start_s[0] = 1'b1; base_s[0] = 8'h80; len_s[0] = 9'd5;
    cyc();
    start_s[0] = 1'b0;
    wait_done(0, 20);
    check_beats(0, 32, 3, 256);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t4_no_restart_cs", {63'd0, cs_s[0]}, 64'd0);
    end

    // Reset during the third beat, then a normal burst
    burst_start(0, 8'h30, 9'd8);
    repeat (4) cyc();
    chk("t5_pre_valid", {63'd0, valid_s[0]}, 64'd1);
    chk("t5_pre_data", data_s[0], mem_word(8'h32));
    rst = 1'b1;
    #1;
    chk("t5_rst_ctl", {58'd0, busy_s[0], done_s[0], cs_s[0], we_s[0], valid_s[0], last_s[0]}, 64'd0);
    chk("t5_rst_addr", {56'd0, addr_s[0]}, 64'd0);
    chk("t5_rst_data", data_s[0], 64'd0);
    cyc();
    rst = 1'b0;
    bq0.delete();
    burst_start(0, 8'h40, 9'd2);
    wait_done(0, 20);
    check_beats(0, 64, 2, 256);

    // RD_LAT=3 with random backpressure
    max_occ = 0;
    first_v = -1;
    seen = 1'b0;
    burst_start(2, 8'h70, 9'd16);
    for (int c = 1; c < 400 && !seen; c++) begin
      rdy_s[2] = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (valid_s[2] && first_v < 0) first_v = c;
      if (done_s[2]) begin
        seen = 1'b1;
        chk("t6_done_with_last_hs", {61'd0, valid_s[2], rdy_s[2], last_s[2]}, 64'd7);
      end
      cyc();
    end
    if (!seen) chk("t6_done_timeout", 64'd0, 64'd1);
    chk("t6_first_valid_cycle", 64'(first_v), 64'd5);
    chk("t6_busy_after_done", {63'd0, busy_s[2]}, 64'd0);
    check_beats(2, 112, 16, 256);
    chk("t6_fifo_max_le4", {63'd0, (max_occ <= 4)}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
